// File: rtl/compass_pkg.sv
// compass_pkg: shared constants for the compass heading controller.
// Holds the motion_mode encoding, the heading width and the default
// divider values. Optional feature macro used by the top: COMPASS_CARDINAL_EN.
package compass_pkg;

    localparam int unsigned HEADING_W        = 10;
    localparam int unsigned DEFAULT_SLOW_DIV = 20_000_000;
    localparam int unsigned DEFAULT_FAST_DIV = 10_000_000;

    typedef enum logic [2:0] {
        MODE_STOP = 3'b000,
        MODE_R1X  = 3'b001,
        MODE_R2X  = 3'b010,
        MODE_L1X  = 3'b011,
        MODE_L2X  = 3'b100,
        MODE_FWD  = 3'b101,
        MODE_REV  = 3'b110,
        MODE_RSVD = 3'b111
    } motion_mode_e;

    // Shift-and-add-3 conversion of a 0..999 binary value to three BCD digits
    // {hundreds, tens, ones}. Used only for presets and elaboration constants.
    function automatic logic [11:0] bin_to_bcd(input logic [HEADING_W-1:0] bin);
        logic [21:0] sr;
        sr = {12'd0, bin};
        for (int unsigned i = 0; i < HEADING_W; i++) begin
            if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
            if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
            if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
            sr = sr << 1;
        end
        return sr[21:10];
    endfunction

endpackage

// File: rtl/compass_tick_gen.sv
// compass_tick_gen: free-running 0..DIV-1 divider with a one-cycle tick
// at the terminal count. Never cleared except by reset.
module compass_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned     CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider count wraps at the terminal value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Gated by reset so the tick is low while reset is held, even for DIV of 1.
    assign tick = reset && (cnt == LAST);

endmodule

// File: rtl/compass_heading_ctrl.sv
// compass_heading_ctrl: heading register stepped left/right at 1X or 2X rate,
// with BCD digits counted in lockstep and a clamped preset load.
// Optional macro COMPASS_CARDINAL_EN adds cardinal[1:0] and cardinal_hit.
module compass_heading_ctrl
    import compass_pkg::*;
#(
    parameter int unsigned SLOW_DIV    = DEFAULT_SLOW_DIV,
    parameter int unsigned FAST_DIV    = DEFAULT_FAST_DIV,
    parameter int unsigned HEADING_MAX = 359
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           motion_mode,
    input  logic                 load,
    input  logic [HEADING_W-1:0] load_heading,
    output logic [HEADING_W-1:0] heading,
    output logic [4:0]           d1,
    output logic [4:0]           d2,
    output logic [4:0]           d3,
    output logic                 step
`ifdef COMPASS_CARDINAL_EN
    ,
    output logic [1:0]           cardinal,
    output logic                 cardinal_hit
`endif
);

    localparam logic [HEADING_W-1:0] HMAX    = HEADING_W'(HEADING_MAX);
    localparam logic [11:0]          MAX_BCD = bin_to_bcd(HMAX);

    logic slow_tick, fast_tick;

    compass_tick_gen #(.DIV(SLOW_DIV)) u_slow_div (
        .clk   (clk),
        .reset (reset),
        .tick  (slow_tick)
    );

    compass_tick_gen #(.DIV(FAST_DIV)) u_fast_div (
        .clk   (clk),
        .reset (reset),
        .tick  (fast_tick)
    );

    motion_mode_e mode;
    assign mode = motion_mode_e'(motion_mode);

    logic                 inc, dec;
    logic [HEADING_W-1:0] heading_q, heading_d, load_val;
    logic [3:0]           d1_q, d2_q, d3_q, d1_d, d2_d, d3_d;
    logic                 step_q, step_d;

    // Select which tick (if any) moves the heading, and in which direction.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        case (mode)
            MODE_R1X: dec = slow_tick;
            MODE_L1X: inc = slow_tick;
            MODE_R2X: dec = fast_tick;
            MODE_L2X: inc = fast_tick;
            default:  ;
        endcase
    end

    assign load_val = (load_heading > HMAX) ? HMAX : load_heading;

    // Next heading and BCD digits; load wins over a coincident tick and never steps.
    always_comb begin
        heading_d = heading_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        step_d    = 1'b0;
        if (load) begin
            heading_d          = load_val;
            {d3_d, d2_d, d1_d} = bin_to_bcd(load_val);
        end else if (inc) begin
            step_d = 1'b1;
            if (heading_q == HMAX) begin
                heading_d = '0;
                d1_d      = '0;
                d2_d      = '0;
                d3_d      = '0;
            end else begin
                heading_d = heading_q + HEADING_W'(1);
                if (d1_q == 4'd9) begin
                    d1_d = '0;
                    if (d2_q == 4'd9) begin
                        d2_d = '0;
                        d3_d = d3_q + 4'd1;
                    end else begin
                        d2_d = d2_q + 4'd1;
                    end
                end else begin
                    d1_d = d1_q + 4'd1;
                end
            end
        end else if (dec) begin
            step_d = 1'b1;
            if (heading_q == '0) begin
                heading_d          = HMAX;
                {d3_d, d2_d, d1_d} = MAX_BCD;
            end else begin
                heading_d = heading_q - HEADING_W'(1);
                if (d1_q == 4'd0) begin
                    d1_d = 4'd9;
                    if (d2_q == 4'd0) begin
                        d2_d = 4'd9;
                        d3_d = d3_q - 4'd1;
                    end else begin
                        d2_d = d2_q - 4'd1;
                    end
                end else begin
                    d1_d = d1_q - 4'd1;
                end
            end
        end
    end

    // Heading, BCD and step registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heading_q <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            step_q    <= 1'b0;
        end else begin
            heading_q <= heading_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            step_q    <= step_d;
        end
    end

    assign heading = heading_q;
    assign d1      = {1'b0, d1_q};
    assign d2      = {1'b0, d2_q};
    assign d3      = {1'b0, d3_q};
    assign step    = step_q;

`ifdef COMPASS_CARDINAL_EN
    logic hit_q, hit_d;

    // A step landing on one of the four cardinal points.
    always_comb begin
        hit_d = step_d && ((heading_d == 10'd0)   || (heading_d == 10'd90) ||
                           (heading_d == 10'd180) || (heading_d == 10'd270));
    end

    // Cardinal-hit pulse register, aligned with step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    // Quadrant decode; only meaningful for a 0..359 compass, otherwise N.
    always_comb begin
        cardinal = 2'b00;
        if (HEADING_MAX == 359) begin
            if (heading_q < 10'd45 || heading_q >= 10'd315) cardinal = 2'b00;
            else if (heading_q < 10'd135)                   cardinal = 2'b01;
            else if (heading_q < 10'd225)                   cardinal = 2'b10;
            else                                            cardinal = 2'b11;
        end
    end

    assign cardinal_hit = hit_q;
`endif

endmodule
